// File: rtl/bram_axis_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bram_axis_streamer
// Brief    : Reads a frame from pixel BRAM and sends it as an AXI4-Stream
//            master, one word per beat. Defining BRAM_AXIS_GRAY2RGB_EN
//            expands each gray pixel to an RGB triplet.
// Revision : 1.0 - initial release
// ============================================================================
module bram_axis_streamer #(
    parameter int n             = 24,
    parameter int pixel_per_clk = 8,
    parameter int addr_width    = 14,
    parameter int line_words    = 80,
    parameter int num_lines     = 120
) (
    input  logic                       ACLK,
    input  logic                       rst,
    input  logic                       start,
    output logic                       bram_en,
    output logic [addr_width-1:0]      bram_addr,
    input  logic [8*pixel_per_clk-1:0] bram_data_out,
    output logic                       m_TVALID,
    input  logic                       m_TREADY,
    output logic [8*n-1:0]             m_TDATA,
    output logic [n-1:0]               m_TSTRB,
    output logic [n-1:0]               m_TKEEP,
    output logic                       m_TLAST,
    output logic                       m_TUSER,
    output logic                       m_TID,
    output logic                       m_TDEST,
    output logic                       busy,
    output logic                       done
);

    localparam int                    c_WW          = 8 * pixel_per_clk;
    localparam int                    c_FRAME_WORDS = line_words * num_lines;
    localparam int                    c_COL_W       = (line_words > 1) ? $clog2(line_words) : 1;
    localparam logic [addr_width-1:0] c_LAST_ADDR   = addr_width'(c_FRAME_WORDS - 1);
    localparam logic [c_COL_W-1:0]    c_LAST_COL    = c_COL_W'(line_words - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [addr_width-1:0]   addr_q;
    logic [c_COL_W-1:0]      col_q;
    logic                    busy_q;
    logic                    done_q;

    // Buffer slots hold {TLAST, TUSER, word}; head_q always drives the bus.
    logic [c_WW+1:0]         head_q;
    logic [c_WW+1:0]         tail_q;
    logic [1:0]              occ_q;
    logic [1:0]              occ_d;
    logic                    inflight_q;
    logic [1:0]              inflight_meta_q;

    logic                    w_pop;
    logic                    w_issue;
    logic [2:0]              w_pending;
    logic [c_WW-1:0]         w_head_data;
    logic [n-1:0]            w_keep;

    assign w_pop     = (occ_q != 2'd0) && m_TREADY;
    assign w_pending = {1'b0, occ_q} + {2'b00, inflight_q};
    // A slot freed by this cycle's pop is free again before the new read lands.
    assign w_issue   = (state_q == S_STREAM) && ((w_pending < 3'd2) || w_pop);

    always_comb begin
        occ_d = occ_q;
        case ({inflight_q, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_STREAM;
                        addr_q  <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        addr_q <= addr_q + addr_width'(1);
                        col_q  <= (col_q == c_LAST_COL) ? '0 : col_q + c_COL_W'(1);
                        if (addr_q == c_LAST_ADDR) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (occ_d == 2'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            occ_q           <= 2'd0;
            head_q          <= '0;
            tail_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_meta_q <= 2'b00;
        end else begin
            occ_q           <= occ_d;
            inflight_q      <= w_issue;
            inflight_meta_q <= {w_issue && (col_q == c_LAST_COL),
                                w_issue && (addr_q == '0)};
            if (w_pop) begin
                head_q <= tail_q;
            end
            if (inflight_q) begin
                if ((occ_q == 2'd0) || ((occ_q == 2'd1) && w_pop)) begin
                    head_q <= {inflight_meta_q, bram_data_out};
                end else begin
                    tail_q <= {inflight_meta_q, bram_data_out};
                end
            end
        end
    end

    assign w_head_data = head_q[c_WW-1:0];

`ifdef BRAM_AXIS_GRAY2RGB_EN
    for (genvar j = 0; j < pixel_per_clk; j++) begin : g_rgb
        assign m_TDATA[24*j +: 24] = {3{w_head_data[8*j +: 8]}};
    end
    assign w_keep = '1;
`else
    assign m_TDATA = (8*n)'(w_head_data);
    assign w_keep  = n'({pixel_per_clk{1'b1}});
`endif

    assign bram_en   = w_issue;
    assign bram_addr = addr_q;
    assign m_TVALID  = (occ_q != 2'd0);
    assign m_TLAST   = head_q[c_WW+1];
    assign m_TUSER   = head_q[c_WW];
    assign m_TKEEP   = m_TVALID ? w_keep : '0;
    assign m_TSTRB   = m_TVALID ? w_keep : '0;
    assign m_TID     = 1'b0;
    assign m_TDEST   = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_axis_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_axis_streamer
// Brief    : Directed self-checking bench for bram_axis_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_axis_streamer;

    localparam int FRAME = 9600;

    logic         ACLK = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         m_TREADY = 1'b0;
    logic         bram_en;
    logic [13:0]  bram_addr;
    logic [63:0]  bram_data_out = '0;
    logic         m_TVALID;
    logic [191:0] m_TDATA;
    logic [23:0]  m_TSTRB;
    logic [23:0]  m_TKEEP;
    logic         m_TLAST;
    logic         m_TUSER;
    logic         m_TID;
    logic         m_TDEST;
    logic         busy;
    logic         done;
    logic         pattern = 1'b0;

    int checks = 0;
    int errors = 0;

    // Per-frame statistics gathered by run_frame and judged by each test.
    int           s_beats, s_bad, s_bad_idx, s_unstable, s_ahead, s_addr_bad;
    int           s_first_en, s_first_valid, s_last_beat, s_done_cyc, s_done_cnt;
    int           s_stall_issued, s_en_in_stall;
    logic         s_busy_start, s_busy_at_done, s_fin;
    logic [193:0] s_bad_act, s_bad_exp;

    bram_axis_streamer dut (
        .ACLK          (ACLK),
        .rst           (rst),
        .start         (start),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_data_out (bram_data_out),
        .m_TVALID      (m_TVALID),
        .m_TREADY      (m_TREADY),
        .m_TDATA       (m_TDATA),
        .m_TSTRB       (m_TSTRB),
        .m_TKEEP       (m_TKEEP),
        .m_TLAST       (m_TLAST),
        .m_TUSER       (m_TUSER),
        .m_TID         (m_TID),
        .m_TDEST       (m_TDEST),
        .busy          (busy),
        .done          (done)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (bram_en) begin
            bram_data_out <= (pattern && bram_addr == 14'd0) ? 64'h0807060504030201 : 64'(bram_addr);
        end
    end

    function automatic logic [191:0] fmt(input logic [63:0] w);
        logic [191:0] r;
        r = '0;
`ifdef BRAM_AXIS_GRAY2RGB_EN
        for (int j = 0; j < 8; j++) r[24*j +: 24] = {3{w[8*j +: 8]}};
`else
        r[63:0] = w;
`endif
        return r;
    endfunction

    task automatic run_frame(input bit rnd, input int stall_at, input int start_at);
        int beat, issued, stall_left, stall_idx, post;
        bit hold, in_stall, start_sent;
        logic [193:0] prev, cur, exp_v;
        beat = 0; issued = 0; stall_left = 0; stall_idx = 0; post = 0;
        hold = 0; start_sent = 0; prev = '0;
        s_bad = 0; s_unstable = 0; s_ahead = 0; s_addr_bad = 0;
        s_first_en = -1; s_first_valid = -1; s_last_beat = -1;
        s_done_cyc = -1; s_done_cnt = 0; s_stall_issued = -1; s_en_in_stall = 0;
        s_busy_start = 0; s_busy_at_done = 1; s_fin = 0;
        s_bad_idx = -1; s_bad_act = '0; s_bad_exp = '0;
        for (int cyc = 0; cyc < 40000 && post < 3; cyc++) begin
            @(negedge ACLK);
            in_stall = (stall_left > 0);
            if (in_stall) begin
                m_TREADY = 1'b0;
                stall_left--;
                stall_idx++;
            end else begin
                m_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = (cyc == 0) || (start_at >= 0 && beat == start_at && !start_sent);
            if (cyc != 0 && start) start_sent = 1;
            #1;
            if (cyc == 1) s_busy_start = busy;
            if (done) begin
                s_done_cnt++;
                if (s_done_cyc < 0) begin
                    s_done_cyc = cyc;
                    s_busy_at_done = busy;
                end
            end
            cur = {m_TLAST, m_TUSER, m_TDATA};
            if (hold && (!m_TVALID || cur !== prev)) s_unstable++;
            if (m_TVALID && s_first_valid < 0) s_first_valid = cyc;
            if (bram_en) begin
                if (s_first_en < 0) s_first_en = cyc;
                if (bram_addr !== 14'(issued)) s_addr_bad++;
                issued++;
                if (in_stall && stall_idx >= 2) s_en_in_stall++;
            end
            if (in_stall && stall_left == 0) s_stall_issued = issued;
            if (m_TVALID && m_TREADY) begin
                exp_v = {(beat % 80 == 79), (beat == 0), fmt(64'(beat))};
                if (cur !== exp_v) begin
                    if (s_bad == 0) begin
                        s_bad_idx = beat;
                        s_bad_act = cur;
                        s_bad_exp = exp_v;
                    end
                    s_bad++;
                end
                if (beat == stall_at) begin
                    stall_left = 20;
                    stall_idx = 0;
                end
                beat++;
                s_last_beat = cyc;
            end
            if (issued - beat > 2) s_ahead++;
            hold = m_TVALID && !m_TREADY;
            prev = cur;
            if (s_fin) post++;
            else if (done) s_fin = 1;
        end
        start = 1'b0;
        s_beats = beat;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bram_en, bram_addr, m_TVALID, m_TDATA, m_TLAST, m_TUSER, m_TKEEP, m_TSTRB,
             m_TID, m_TDEST, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d valid=%b keep=%h busy=%b done=%b, want all 0",
                     bram_en, bram_addr, m_TVALID, m_TKEEP, busy, done);
        end
        repeat (3) @(negedge ACLK);
        rst = 1'b0;
        @(negedge ACLK);
        #1;
        checks++;
        if ({bram_en, m_TVALID, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got en=%b valid=%b busy=%b done=%b, want 0000",
                     bram_en, m_TVALID, busy, done);
        end
    endtask

    task automatic test_free_flow();
        run_frame(1'b0, -1, -1);
        checks++;
        if (s_fin !== 1'b1) begin errors++; $display("FAIL ff_done_seen: got %b want 1 (timeout)", s_fin); end
        checks++;
        if (s_beats != FRAME) begin errors++; $display("FAIL ff_beats: got %0d want %0d", s_beats, FRAME); end
        checks++;
        if (s_bad != 0) begin
            errors++;
            $display("FAIL ff_beat_content: %0d bad, first beat %0d got %h want %h", s_bad, s_bad_idx, s_bad_act, s_bad_exp);
        end
        checks++;
        if (s_last_beat - s_first_valid != FRAME - 1) begin
            errors++;
            $display("FAIL ff_throughput: got span %0d want %0d", s_last_beat - s_first_valid, FRAME - 1);
        end
        checks++;
        if (s_done_cyc - s_last_beat != 1) begin
            errors++;
            $display("FAIL ff_done_latency: got %0d want 1", s_done_cyc - s_last_beat);
        end
        checks++;
        if (s_first_en != 1) begin errors++; $display("FAIL ff_first_read: got cycle %0d want 1", s_first_en); end
        checks++;
        if (s_busy_start !== 1'b1 || s_busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL ff_busy: got start=%b at_done=%b want 1/0", s_busy_start, s_busy_at_done);
        end
        checks++;
        if (s_done_cnt != 1) begin errors++; $display("FAIL ff_done_pulses: got %0d want 1", s_done_cnt); end
        checks++;
        if (s_addr_bad != 0) begin errors++; $display("FAIL ff_addr_seq: got %0d bad addrs want 0", s_addr_bad); end
    endtask

    task automatic test_random_ready();
        run_frame(1'b1, -1, -1);
        checks++;
        if (s_fin !== 1'b1 || s_beats != FRAME) begin
            errors++;
            $display("FAIL rnd_beats: got fin=%b beats=%0d want 1/%0d", s_fin, s_beats, FRAME);
        end
        checks++;
        if (s_bad != 0) begin
            errors++;
            $display("FAIL rnd_beat_content: %0d bad, first beat %0d got %h want %h", s_bad, s_bad_idx, s_bad_act, s_bad_exp);
        end
        checks++;
        if (s_unstable != 0) begin errors++; $display("FAIL rnd_stable: got %0d changes under backpressure want 0", s_unstable); end
        checks++;
        if (s_ahead != 0) begin errors++; $display("FAIL rnd_read_ahead: got %0d overruns want 0", s_ahead); end
        checks++;
        if (s_addr_bad != 0) begin errors++; $display("FAIL rnd_addr_seq: got %0d bad addrs want 0", s_addr_bad); end
    endtask

    task automatic test_stall();
        run_frame(1'b0, 5, -1);
        checks++;
        if (s_stall_issued != 8) begin errors++; $display("FAIL stall_reads: got %0d issued want 8", s_stall_issued); end
        checks++;
        if (s_en_in_stall != 0) begin errors++; $display("FAIL stall_en_low: got %0d reads during stall want 0", s_en_in_stall); end
        checks++;
        if (s_fin !== 1'b1 || s_beats != FRAME || s_bad != 0 || s_unstable != 0) begin
            errors++;
            $display("FAIL stall_frame: got fin=%b beats=%0d bad=%0d unstable=%0d want 1/%0d/0/0",
                     s_fin, s_beats, s_bad, s_unstable, FRAME);
        end
    endtask

    task automatic test_start_ignored();
        run_frame(1'b0, -1, 100);
        checks++;
        if (s_fin !== 1'b1 || s_beats != FRAME || s_bad != 0) begin
            errors++;
            $display("FAIL start_ignored: got fin=%b beats=%0d bad=%0d want 1/%0d/0", s_fin, s_beats, s_bad, FRAME);
        end
        checks++;
        if (s_done_cnt != 1) begin errors++; $display("FAIL start_ignored_done: got %0d pulses want 1", s_done_cnt); end
    endtask

    task automatic test_reset_midframe();
        int beat;
        bit found;
        beat = 0;
        m_TREADY = 1'b1;
        for (int cyc = 0; cyc < 2000 && beat < 500; cyc++) begin
            @(negedge ACLK);
            start = (cyc == 0);
            #1;
            if (m_TVALID && m_TREADY) beat++;
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (beat != 500 || {bram_en, bram_addr, m_TVALID, m_TDATA, m_TLAST, m_TUSER, m_TKEEP, busy, done} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got beats=%0d en=%b addr=%0d valid=%b busy=%b, want 500 and all 0",
                     beat, bram_en, bram_addr, m_TVALID, busy);
        end
        @(negedge ACLK);
        rst = 1'b0;
        @(negedge ACLK);
        start = 1'b1;
        m_TREADY = 1'b0;
        @(negedge ACLK);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            #1;
            if (m_TVALID) found = 1;
            else @(negedge ACLK);
        end
        checks++;
        if (!found || m_TDATA !== fmt(64'd0) || m_TUSER !== 1'b1) begin
            errors++;
            $display("FAIL restart_beat0: got valid=%b user=%b data=%h want 1/1/%h", m_TVALID, m_TUSER, m_TDATA, fmt(64'd0));
        end
    endtask

    task automatic test_format();
        logic [191:0] want_data;
        logic [23:0]  want_keep;
        bit found;
`ifdef BRAM_AXIS_GRAY2RGB_EN
        want_data = 192'h080808_070707_060606_050505_040404_030303_020202_010101;
        want_keep = 24'hFFFFFF;
`else
        want_data = {128'h0, 64'h0807060504030201};
        want_keep = 24'h0000FF;
`endif
        @(negedge ACLK);
        rst = 1'b1;
        pattern = 1'b1;
        m_TREADY = 1'b0;
        @(negedge ACLK);
        rst = 1'b0;
        @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            #1;
            if (m_TVALID) found = 1;
            else @(negedge ACLK);
        end
        checks++;
        if (!found || m_TDATA !== want_data) begin
            errors++;
            $display("FAIL format_tdata: got valid=%b data=%h want %h", m_TVALID, m_TDATA, want_data);
        end
        checks++;
        if (m_TKEEP !== want_keep || m_TSTRB !== want_keep) begin
            errors++;
            $display("FAIL format_tkeep: got keep=%h strb=%h want %h", m_TKEEP, m_TSTRB, want_keep);
        end
        checks++;
        if (m_TID !== 1'b0 || m_TDEST !== 1'b0 || m_TUSER !== 1'b1) begin
            errors++;
            $display("FAIL format_sideband: got id=%b dest=%b user=%b want 0/0/1", m_TID, m_TDEST, m_TUSER);
        end
        rst = 1'b1;
        pattern = 1'b0;
        @(negedge ACLK);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_flow();
        test_random_ready();
        test_stall();
        test_start_ignored();
        test_reset_midframe();
        test_format();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
